// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared command codes, step counts and sequencer state encoding
package i2c_pkg;

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b011;
  localparam logic [2:0] CMD_WR_STOP = 3'b111;
  localparam logic [2:0] CMD_RD_STOP = 3'b101;
  localparam logic [2:0] CMD_STOP    = 3'b100;

  localparam int WR_STEPS = 3;
  localparam int RD_STEPS = 4;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_ABORT,
    ST_ABORT_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/i2c_step_rom.sv
// rtl/i2c_step_rom.sv - maps (rw, step) of a register transaction to the engine byte command
module i2c_step_rom
  import i2c_pkg::*;
(
  input  logic       rw_i,
  input  logic [1:0] step_i,
  input  logic [6:0] dev_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] wdata_i,
  output logic [2:0] cmd_o,
  output logic [7:0] dout_o,
  output logic       last_o
);

  always_comb begin
    cmd_o  = CMD_IDLE;
    dout_o = 8'h00;
    last_o = 1'b0;
    if (!rw_i) begin
      case (step_i)
        2'd0: begin cmd_o = CMD_WR;      dout_o = {dev_i, 1'b0}; end
        2'd1: begin cmd_o = CMD_WR;      dout_o = reg_i;         end
        2'd2: begin cmd_o = CMD_WR_STOP; dout_o = wdata_i;       end
        default: ;
      endcase
      last_o = (step_i == 2'(WR_STEPS - 1));
    end else begin
      // Register index goes out with its own stop, then a fresh start for the read phase.
      case (step_i)
        2'd0: begin cmd_o = CMD_WR;      dout_o = {dev_i, 1'b0}; end
        2'd1: begin cmd_o = CMD_WR_STOP; dout_o = reg_i;         end
        2'd2: begin cmd_o = CMD_WR;      dout_o = {dev_i, 1'b1}; end
        default: begin cmd_o = CMD_RD_STOP; dout_o = 8'h00;      end
      endcase
      last_o = (step_i == 2'(RD_STEPS - 1));
    end
  end

endmodule

// File: rtl/i2c_reg_seq.sv
// rtl/i2c_reg_seq.sv - expands register read/write requests into i2c engine byte commands with retry
module i2c_reg_seq
  import i2c_pkg::*;
#(
  parameter int unsigned INIT_DLY = 4,
  parameter int unsigned BUSY_TO  = 255,
  parameter int unsigned RETRIES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [6:0] dev_addr_i,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] wdata_i,
  output logic       ack_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic [2:0] i2c_cmd_o,
  output logic [7:0] i2c_dout_o,
  input  logic [7:0] i2c_din_i,
  input  logic       i2c_busy_i,
  input  logic       i2c_error_i
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_DLY - 1);
  localparam logic [7:0] BUSY_LIM  = 8'(BUSY_TO);
  localparam logic [1:0] RETRY_LIM = 2'(RETRIES);

  state_e     state_q;
  logic [1:0] step_q, try_q;
  logic [7:0] cnt_q;
  logic       rw_q, hi_q, fail_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q, rd_q;
  logic       ack_q, done_q, err_q, busy_q;
  logic [7:0] rdata_q, dout_q;
  logic [2:0] cmd_q;

  logic [2:0] rom_cmd;
  logic [7:0] rom_dout;
  logic       rom_last;
  logic       abort_end;

  i2c_step_rom u_rom (
    .rw_i   (rw_q),
    .step_i (step_q),
    .dev_i  (dev_q),
    .reg_i  (reg_q),
    .wdata_i(wdata_q),
    .cmd_o  (rom_cmd),
    .dout_o (rom_dout),
    .last_o (rom_last)
  );

  // The abort stop finishes on its busy fall, or on timeout; its error flag is ignored.
  assign abort_end = !i2c_busy_i && (hi_q || cnt_q == BUSY_LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      step_q  <= 2'd0;
      try_q   <= 2'd0;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      hi_q    <= 1'b0;
      fail_q  <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wdata_q <= 8'd0;
      rd_q    <= 8'd0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
      rdata_q <= 8'd0;
      dout_q  <= 8'd0;
      cmd_q   <= CMD_IDLE;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cmd_q  <= CMD_IDLE;
      case (state_q)
        ST_INIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_q   <= 8'd0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_IDLE: begin
          busy_q <= req_i;
          if (req_i) begin
            ack_q   <= 1'b1;
            rw_q    <= rw_i;
            dev_q   <= dev_addr_i;
            reg_q   <= reg_addr_i;
            wdata_q <= wdata_i;
            step_q  <= 2'd0;
            try_q   <= 2'd0;
            fail_q  <= 1'b0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!i2c_busy_i) begin
            cmd_q   <= rom_cmd;
            dout_q  <= rom_dout;
            cnt_q   <= 8'd0;
            state_q <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (i2c_busy_i) begin
            state_q <= ST_WAIT_LO;
          end else if (cnt_q == BUSY_LIM) begin
            fail_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WAIT_LO: begin
          if (!i2c_busy_i) begin
            if (i2c_error_i) begin
              state_q <= ST_ABORT;
            end else if (rom_last) begin
              rd_q    <= i2c_din_i;
              state_q <= ST_DONE;
            end else begin
              step_q  <= step_q + 2'd1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ABORT: begin
          if (!i2c_busy_i) begin
            cmd_q   <= CMD_STOP;
            dout_q  <= 8'h00;
            cnt_q   <= 8'd0;
            hi_q    <= 1'b0;
            state_q <= ST_ABORT_WAIT;
          end
        end
        ST_ABORT_WAIT: begin
          if (!hi_q) begin
            if (i2c_busy_i) hi_q <= 1'b1;
            else if (cnt_q != BUSY_LIM) cnt_q <= cnt_q + 8'd1;
          end
          if (abort_end) begin
            if (try_q < RETRY_LIM) begin
              try_q   <= try_q + 2'd1;
              step_q  <= 2'd0;
              state_q <= ST_ISSUE;
            end else begin
              fail_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          err_q   <= fail_q;
          if (!fail_q && rw_q) rdata_q <= rd_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign i2c_cmd_o  = cmd_q;
  assign i2c_dout_o = dout_q;

endmodule
